// File: rtl/aes_avl_pkg.sv
// Shared types and register map for the AES Avalon-MM master.
// The state enum and slave register addresses live here so the bench and RTL agree.
package aes_avl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_KEY    = 3'd1,
    WR_MSG    = 3'd2,
    WR_START  = 3'd3,
    POLL      = 3'd4,
    RD_DEC    = 3'd5,
    CLR_START = 3'd6,
    FINISH    = 3'd7
  } aes_state_e;

  localparam logic [3:0] ADDR_KEY0  = 4'd0;
  localparam logic [3:0] ADDR_MSG0  = 4'd4;
  localparam logic [3:0] ADDR_DEC0  = 4'd8;
  localparam logic [3:0] ADDR_START = 4'd14;
  localparam logic [3:0] ADDR_DONE  = 4'd15;

  // Word i of a 128-bit block, word 0 being the most significant.
  function automatic logic [31:0] word_msb(input logic [127:0] v, input logic [1:0] i);
    logic [31:0] w;
    case (i)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_avl_master.sv
// Avalon-MM master that loads key/ciphertext into an AES slave, starts it,
// polls for completion and reads back the plaintext.
//
// state     | meaning
// IDLE      | waiting for START
// WR_KEY    | writing key words to addresses 0..3
// WR_MSG    | writing ciphertext words to addresses 4..7
// WR_START  | writing 1 to the slave start register
// POLL      | reading the slave done register until set or limit reached
// RD_DEC    | reading plaintext words from addresses 8..11
// CLR_START | writing 0 to the slave start register
// FINISH    | one-cycle DONE pulse
module aes_avl_master
  import aes_avl_pkg::*;
#(
  parameter int POLL_LIMIT = 4096
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         START,
  input  logic [127:0] KEY,
  input  logic [127:0] MSG_ENC,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERROR,
  output logic [127:0] MSG_DEC,
  output logic         AVM_READ,
  output logic         AVM_WRITE,
  output logic         AVM_CS,
  output logic [3:0]   AVM_BYTE_EN,
  output logic [3:0]   AVM_ADDR,
  output logic [31:0]  AVM_WRITEDATA,
  input  logic [31:0]  AVM_READDATA,
  input  logic         AVM_WAITREQUEST
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_MAX  = PCW'(POLL_LIMIT);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  aes_state_e     state_q, state_d;
  logic [127:0]   key_q, msg_q, dec_q;
  logic [3:0]     idx_q;
  logic [PCW-1:0] poll_q;
  logic           err_q;

  logic xfer, last_word, accept, poll_fail, dec_we, burst;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Bus outputs are decoded from state only, so they stay put while stalled.
  always_comb begin
    state_d       = state_q;
    AVM_READ      = 1'b0;
    AVM_WRITE     = 1'b0;
    AVM_CS        = 1'b0;
    AVM_BYTE_EN   = 4'h0;
    AVM_ADDR      = 4'h0;
    AVM_WRITEDATA = 32'h0;
    accept        = 1'b0;
    poll_fail     = 1'b0;
    dec_we        = 1'b0;
    last_word     = (idx_q == 4'd3);
    burst         = (state_q == WR_KEY) || (state_q == WR_MSG) || (state_q == RD_DEC);
    xfer          = (state_q != IDLE) && (state_q != FINISH) && !AVM_WAITREQUEST;
    case (state_q)
      IDLE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = WR_KEY;
        end
      end
      WR_KEY: begin
        AVM_CS        = 1'b1;
        AVM_WRITE     = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = ADDR_KEY0 + idx_q;
        AVM_WRITEDATA = word_msb(key_q, idx_q[1:0]);
        if (xfer && last_word) state_d = WR_MSG;
      end
      WR_MSG: begin
        AVM_CS        = 1'b1;
        AVM_WRITE     = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = ADDR_MSG0 + idx_q;
        AVM_WRITEDATA = word_msb(msg_q, idx_q[1:0]);
        if (xfer && last_word) state_d = WR_START;
      end
      WR_START: begin
        AVM_CS        = 1'b1;
        AVM_WRITE     = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = ADDR_START;
        AVM_WRITEDATA = 32'h0000_0001;
        if (xfer) state_d = POLL;
      end
      POLL: begin
        AVM_CS      = 1'b1;
        AVM_READ    = 1'b1;
        AVM_BYTE_EN = 4'hF;
        AVM_ADDR    = ADDR_DONE;
        if (xfer) begin
          if (AVM_READDATA[0]) begin
            state_d = RD_DEC;
          end else if (poll_q >= POLL_LAST) begin
            poll_fail = 1'b1;
            state_d   = CLR_START;
          end
        end
      end
      RD_DEC: begin
        AVM_CS      = 1'b1;
        AVM_READ    = 1'b1;
        AVM_BYTE_EN = 4'hF;
        AVM_ADDR    = ADDR_DEC0 + idx_q;
        if (xfer) begin
          dec_we = 1'b1;
          if (last_word) state_d = CLR_START;
        end
      end
      CLR_START: begin
        AVM_CS        = 1'b1;
        AVM_WRITE     = 1'b1;
        AVM_BYTE_EN   = 4'hF;
        AVM_ADDR      = ADDR_START;
        AVM_WRITEDATA = 32'h0000_0000;
        if (xfer) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_q  <= '0;
      msg_q  <= '0;
      dec_q  <= '0;
      idx_q  <= '0;
      poll_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        key_q  <= KEY;
        msg_q  <= MSG_ENC;
        idx_q  <= '0;
        poll_q <= '0;
        err_q  <= 1'b0;
      end
      if (burst && xfer) idx_q <= last_word ? 4'd0 : idx_q + 4'd1;
      // Counter saturates so a huge limit can never alias back to zero.
      if ((state_q == POLL) && xfer && !AVM_READDATA[0] && (poll_q != POLL_MAX))
        poll_q <= poll_q + 1'b1;
      if (poll_fail) err_q <= 1'b1;
      if (dec_we) begin
        case (idx_q[1:0])
          2'd0:    dec_q[127:96] <= AVM_READDATA;
          2'd1:    dec_q[95:64]  <= AVM_READDATA;
          2'd2:    dec_q[63:32]  <= AVM_READDATA;
          default: dec_q[31:0]   <= AVM_READDATA;
        endcase
      end
    end
  end

  assign BUSY    = (state_q != IDLE);
  assign DONE    = (state_q == FINISH);
  assign ERROR   = (state_q == FINISH) && err_q;
  assign MSG_DEC = dec_q;

endmodule

// File: tb/tb_aes_avl_master.sv
// Bench for aes_avl_master: a behavioural Avalon slave with programmable stalls,
// an expected-transaction model per decryption, and a few reset/START corner cases.
module tb_aes_avl_master;
  import aes_avl_pkg::*;

  localparam int PL = 8;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         START = 1'b0;
  logic [127:0] KEY = '0;
  logic [127:0] MSG_ENC = '0;
  logic         BUSY, DONE, ERROR;
  logic [127:0] MSG_DEC;
  logic         AVM_READ, AVM_WRITE, AVM_CS;
  logic [3:0]   AVM_BYTE_EN, AVM_ADDR;
  logic [31:0]  AVM_WRITEDATA;
  logic [31:0]  AVM_READDATA = '0;
  logic         AVM_WAITREQUEST = 1'b0;

  aes_avl_master #(.POLL_LIMIT(PL)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .KEY(KEY), .MSG_ENC(MSG_ENC),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .MSG_DEC(MSG_DEC),
    .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE), .AVM_CS(AVM_CS),
    .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_ADDR(AVM_ADDR), .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_READDATA(AVM_READDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural slave ----------------
  typedef struct {
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] sregs[16];
  int          done_after = 0;
  int          stall_n = 0;
  int          stall_cnt = 0;
  int          poll_reads = 0;
  logic        prev_stall = 1'b0;
  logic [42:0] prev_bus = '0;
  logic [42:0] bus_now;
  logic        req;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      stall_cnt       = 0;
      prev_stall      = 1'b0;
      AVM_WAITREQUEST = 1'b0;
    end else begin
      req     = AVM_CS && (AVM_READ || AVM_WRITE);
      bus_now = {AVM_READ, AVM_WRITE, AVM_CS, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA};
      if (prev_stall) chk("stall_hold", 128'(bus_now), 128'(prev_bus));
      chk("byte_en", 128'(AVM_BYTE_EN), req ? 128'hF : 128'h0);
      if (!AVM_CS) chk("idle_bus", 128'({AVM_READ, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA}), 128'h0);
      if (req && stall_cnt < stall_n) begin
        AVM_WAITREQUEST = 1'b1;
        AVM_READDATA    = $urandom;
        stall_cnt++;
        prev_stall = 1'b1;
      end else begin
        AVM_WAITREQUEST = 1'b0;
        stall_cnt       = 0;
        prev_stall      = 1'b0;
        AVM_READDATA    = $urandom;
        if (req && AVM_WRITE) begin
          sregs[AVM_ADDR] = AVM_WRITEDATA;
          log_q.push_back('{1'b0, AVM_ADDR, AVM_WRITEDATA});
        end else if (req) begin
          if (AVM_ADDR == ADDR_DONE) begin
            poll_reads++;
            AVM_READDATA = {$urandom_range(0, 1) == 1 ? 31'h7FFF_FFFF : 31'h0,
                            done_after != 0 && poll_reads >= done_after};
          end else begin
            AVM_READDATA = sregs[AVM_ADDR];
          end
          log_q.push_back('{1'b1, AVM_ADDR, 32'h0});
        end
      end
      prev_bus = bus_now;
    end
  end

  // ---------------- reference model and transaction runner ----------------
  logic [127:0] prev_dec = '0;

  task automatic preload_dec();
    for (int i = 8; i < 12; i++) sregs[i] = $urandom;
  endtask

  // Must be entered right at a falling edge; START goes high for one cycle.
  task automatic run_txn(input logic [127:0] key, input logic [127:0] msg, input int da,
                         input int sn, input logic exp_err, input int poke_at);
    txn_t         exp_q[$];
    logic [127:0] exp_dec;
    int           k, ntrans, t, n;
    k = exp_err ? PL : da;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 4'(i), key[127-32*i -: 32]});
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 4'(4 + i), msg[127-32*i -: 32]});
    exp_q.push_back('{1'b0, 4'd14, 32'h1});
    for (int j = 0; j < k; j++) exp_q.push_back('{1'b1, 4'd15, 32'h0});
    if (!exp_err) for (int i = 8; i < 12; i++) exp_q.push_back('{1'b1, 4'(i), 32'h0});
    exp_q.push_back('{1'b0, 4'd14, 32'h0});
    exp_dec = exp_err ? prev_dec : {sregs[8], sregs[9], sregs[10], sregs[11]};
    ntrans  = 9 + k + (exp_err ? 0 : 4) + 1;

    log_q.delete();
    done_after = da;
    stall_n    = sn;
    poll_reads = 0;
    KEY        = key;
    MSG_ENC    = msg;
    START      = 1'b1;
    t          = cyc;
    @(negedge CLK);
    START   = 1'b0;
    KEY     = {$urandom, $urandom, $urandom, $urandom};
    MSG_ENC = {$urandom, $urandom, $urandom, $urandom};
    n = 1;
    while (!DONE && n < 600) begin
      START = (n == poke_at);
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    if (!DONE) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no DONE within %0d cycles", n);
      return;
    end
    chk("done_cycle", 128'(cyc), 128'(t + 1 + ntrans * (sn + 1)));
    chk("error_flag", 128'(ERROR), 128'(exp_err));
    chk("busy_at_done", 128'(BUSY), 128'h1);
    chk("msg_dec", MSG_DEC, exp_dec);
    @(negedge CLK);
    chk("done_pulse", 128'({DONE, ERROR, BUSY}), 128'h0);
    chk("txn_count", 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("txn%0d", i), 128'({log_q[i].rd, log_q[i].addr, log_q[i].data}),
          128'({exp_q[i].rd, exp_q[i].addr, exp_q[i].data}));
    prev_dec = exp_dec;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] msg;
    int           da;
    int           sn;
    logic         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   da, sn, n, extra;
    logic [127:0] rk, rm;
    for (int i = 0; i < 16; i++) sregs[i] = '0;

    vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 128'hDAEC3055DF058E1C39E814EA76F6747E, 3, 0, 1'b0};
    vecs[1] = '{128'h000102030405060708090A0B0C0D0E0F, 128'hDAEC3055DF058E1C39E814EA76F6747E, 3, 2, 1'b0};
    vecs[2] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b1};
    vecs[3] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 1'b0};
    vecs[4] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, PL, 1, 1'b0};
    vecs[5] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, PL + 1, 0, 1'b1};
    vecs[6] = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 5, 3, 1'b0};

    // Reset values
    #12;
    chk("rst_status", 128'({BUSY, DONE, ERROR}), 128'h0);
    chk("rst_msg_dec", MSG_DEC, 128'h0);
    chk("rst_bus", 128'({AVM_READ, AVM_WRITE, AVM_CS, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA}), 128'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;

    // START on the very first edge after reset release
    for (int v = 0; v < 7; v++) begin
      preload_dec();
      run_txn(vecs[v].key, vecs[v].msg, vecs[v].da, vecs[v].sn, vecs[v].exp_err, -1);
      @(negedge CLK);
    end

    // Randomised runs; error outcome derived from the poll limit rule
    for (int r = 0; r < 6; r++) begin
      da = $urandom_range(0, PL + 2);
      sn = $urandom_range(0, 2);
      rk = {$urandom, $urandom, $urandom, $urandom};
      rm = {$urandom, $urandom, $urandom, $urandom};
      preload_dec();
      run_txn(rk, rm, da, sn, (da == 0) || (da > PL), -1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    // START pulsed in the middle of POLL is ignored
    preload_dec();
    run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 6, 0, 1'b0, 11);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      if (DONE || BUSY) extra++;
      @(negedge CLK);
    end
    chk("no_second_run", 128'(extra), 128'h0);

    // Reset while reading the third plaintext word
    preload_dec();
    done_after = 2;
    stall_n    = 0;
    poll_reads = 0;
    KEY        = {$urandom, $urandom, $urandom, $urandom};
    MSG_ENC    = {$urandom, $urandom, $urandom, $urandom};
    START      = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (!(AVM_READ && AVM_ADDR == 4'd10) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_rd_word2", 128'({AVM_READ, AVM_ADDR}), 128'({1'b1, 4'd10}));
    #1 RESET_N = 1'b0;
    #1;
    chk("arst_bus", 128'({AVM_READ, AVM_WRITE, AVM_CS, AVM_BYTE_EN, AVM_ADDR, AVM_WRITEDATA}), 128'h0);
    chk("arst_msg_dec", MSG_DEC, 128'h0);
    chk("arst_status", 128'({BUSY, DONE, ERROR}), 128'h0);
    @(negedge CLK);
    RESET_N  = 1'b1;
    prev_dec = '0;
    preload_dec();
    run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 4, 1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
